osnt_rx_timestamp: RTL and testbench

OSNT_RX_TIMESTAMP -- requirements
Module: osnt_rx_timestamp

---
 rtl/osnt_rx_timestamp_pkg.sv | 15 +
 rtl/osnt_axis_skid_buf.sv | 59 +++++
 rtl/osnt_rx_timestamp.sv | 89 ++++++++
 tb/tb_osnt_rx_timestamp.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_rx_timestamp_pkg.sv
// Shared types and default widths for the receive-side timestamp inserter.
package osnt_rx_timestamp_pkg;

  localparam int C_DATA_WIDTH_DEF  = 256;
  localparam int C_TUSER_WIDTH_DEF = 128;
  localparam int C_TS_WIDTH_DEF    = 64;
  localparam int C_TS_OFFSET_DEF   = 64;
  localparam int C_PKT_COUNT_WIDTH = 32;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_PKT   = 1'b1
  } rx_state_e;

endpackage

// File: rtl/osnt_axis_skid_buf.sv
// Two-entry skid buffer: registered input ready, one-cycle latency, full rate
// when the sink keeps up, output held stable while stalled.
module osnt_axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic [1:0]       w_count_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is registered from the next occupancy, so it only drops once both slots hold data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/osnt_rx_timestamp.sv
// Stamps the first beat of each received packet with the free-running counter
// value at acceptance, then forwards all beats through a two-entry skid buffer.
//
// state    | meaning
// WAIT_SOF | next accepted beat is the first beat of a packet
// IN_PKT   | inside a packet; beats pass through unstamped
module osnt_rx_timestamp
  import osnt_rx_timestamp_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = C_DATA_WIDTH_DEF,
  parameter int C_S_AXIS_TUSER_WIDTH = C_TUSER_WIDTH_DEF,
  parameter int TIMESTAMP_WIDTH      = C_TS_WIDTH_DEF,
  parameter int TS_TUSER_OFFSET      = C_TS_OFFSET_DEF
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [TIMESTAMP_WIDTH-1:0]        STAMP_COUNTER,
  input  logic                              TIMESTAMP_EN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [C_PKT_COUNT_WIDTH-1:0]      PKT_COUNT
);

  localparam int KEEP_W    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PAYLOAD_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;

  rx_state_e                       r_state;
  rx_state_e                       w_state_nxt;
  logic [C_PKT_COUNT_WIDTH-1:0]    r_pkt_count;
  logic                            w_accept;
  logic                            w_first;
  logic                            w_stamp;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic [PAYLOAD_W-1:0]            w_in_payload;
  logic [PAYLOAD_W-1:0]            w_out_payload;

  assign w_accept = s_axis_tvalid & s_axis_tready;
  assign w_first  = (r_state == WAIT_SOF);
  assign w_stamp  = w_accept & w_first & TIMESTAMP_EN;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = s_axis_tlast ? WAIT_SOF : IN_PKT;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= WAIT_SOF;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stamp) r_pkt_count <= r_pkt_count + C_PKT_COUNT_WIDTH'(1);
    end
  end

  // The enable is only looked at on a first beat, so mid-packet changes wait for the next packet.
  always_comb begin
    w_tuser = s_axis_tuser;
    if (w_first && TIMESTAMP_EN) w_tuser[TS_TUSER_OFFSET +: TIMESTAMP_WIDTH] = STAMP_COUNTER;
  end

  assign w_in_payload = {s_axis_tlast, w_tuser, s_axis_tkeep, s_axis_tdata};
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = w_out_payload;
  assign PKT_COUNT = r_pkt_count;

  osnt_axis_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_data  (w_in_payload),
    .i_valid (s_axis_tvalid),
    .o_ready (s_axis_tready),
    .o_data  (w_out_payload),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_osnt_rx_timestamp.sv
// Bench for osnt_rx_timestamp: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_osnt_rx_timestamp;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int TW = 64;
  localparam int TO = 64;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [TW-1:0] STAMP_COUNTER = '0;
  logic          TIMESTAMP_EN = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   PKT_COUNT;

  always #5 ACLK = ~ACLK;

  osnt_rx_timestamp dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .STAMP_COUNTER (STAMP_COUNTER),
    .TIMESTAMP_EN  (TIMESTAMP_EN),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .PKT_COUNT     (PKT_COUNT)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    bit            first;
  } beat_t;

  beat_t         exp_q[$];
  logic [TW-1:0] obs_stamps[$];
  beat_t         mon_e;
  beat_t         mon_n;
  bit            mdl_in_pkt = 1'b0;
  logic [31:0]   mdl_cnt = '0;
  bit            prev_rst = 1'b0;
  int            preset_seq = 0;
  int            seen_seq = 0;
  logic [31:0]   preset_val = '0;
  bit            tog_mode = 1'b0;
  int            tests = 0;
  int            fails = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [UW-1:0] rnd_user();
    logic [UW-1:0] v;
    for (int i = 0; i < UW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Model: every accepted beat must emerge unchanged and in order, except the
  // first beat of a packet whose stamp field carries the counter at acceptance.
  initial forever begin
    @(negedge ACLK);
    #4;
    if (ARESET) begin
      exp_q.delete();
      mdl_in_pkt = 1'b0;
      mdl_cnt    = '0;
      prev_rst   = 1'b1;
    end else begin
      if (preset_seq != seen_seq) begin
        mdl_cnt  = preset_val;
        seen_seq = preset_seq;
      end
      if (prev_rst) begin
        chk("rst_m_valid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("rst_s_ready", DW'(s_axis_tready), DW'(1'b0));
      end else begin
        chk("s_ready", DW'(s_axis_tready), DW'(exp_q.size() < 2));
      end
      chk("m_valid", DW'(m_axis_tvalid), DW'(exp_q.size() != 0));
      if (m_axis_tvalid && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("m_data", m_axis_tdata, mon_e.d);
        chk("m_keep", DW'(m_axis_tkeep), DW'(mon_e.k));
        chk("m_user", DW'(m_axis_tuser), DW'(mon_e.u));
        chk("m_last", DW'(m_axis_tlast), DW'(mon_e.l));
        if (m_axis_tready) begin
          if (mon_e.first) obs_stamps.push_back(m_axis_tuser[TO +: TW]);
          void'(exp_q.pop_front());
        end
      end
      chk("pkt_count", DW'(PKT_COUNT), DW'(mdl_cnt));
      if (s_axis_tvalid && s_axis_tready) begin
        mon_n.d     = s_axis_tdata;
        mon_n.k     = s_axis_tkeep;
        mon_n.u     = s_axis_tuser;
        mon_n.l     = s_axis_tlast;
        mon_n.first = !mdl_in_pkt;
        if (mon_n.first && TIMESTAMP_EN) begin
          mon_n.u[TO +: TW] = STAMP_COUNTER;
          mdl_cnt = mdl_cnt + 32'd1;
        end
        exp_q.push_back(mon_n);
        mdl_in_pkt = !s_axis_tlast;
      end
      prev_rst = 1'b0;
    end
  end

  task automatic step();
    #10;
    STAMP_COUNTER = STAMP_COUNTER + 64'd1;
    if (tog_mode) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                           input logic l, output int waits, output logic [TW-1:0] ts_acc);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waits = 0;
    while (!s_axis_tready && waits < 200) begin
      step();
      waits++;
    end
    if (!s_axis_tready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles at %0t", waits, $time);
    end
    ts_acc = STAMP_COUNTER;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit en, output logic [TW-1:0] ts_first,
                          output logic [UW-1:0] u_first, output int waits_tot);
    int            w;
    logic [TW-1:0] ts;
    logic [UW-1:0] u;
    waits_tot    = 0;
    ts_first     = '0;
    u_first      = '0;
    TIMESTAMP_EN = en;
    for (int i = 0; i < len; i++) begin
      u = rnd_user();
      send_beat(rnd_data(), KW'($urandom()), u, (i == len - 1), w, ts);
      if (i == 0) begin
        ts_first     = ts;
        u_first      = u;
        TIMESTAMP_EN = ~en;
      end
      waits_tot += w;
    end
  endtask

  task automatic drain();
    tog_mode      = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || m_axis_tvalid); i++) step();
    chk("drained", DW'(m_axis_tvalid), DW'(1'b0));
  endtask

  initial begin
    logic [TW-1:0] ts_a, ts_b;
    logic [UW-1:0] u_a, u_b;
    logic [DW-1:0] d0;
    logic [UW-1:0] u0;
    logic [KW-1:0] k0;
    int            wa, wb, base;

    @(negedge ACLK);
    #1;
    step();
    step();
    chk("reset_m_valid", DW'(m_axis_tvalid), DW'(1'b0));
    chk("reset_s_ready", DW'(s_axis_tready), DW'(1'b0));
    chk("reset_pkt_count", DW'(PKT_COUNT), DW'(32'd0));
    ARESET = 1'b0;
    step();
    chk("ready_after_reset", DW'(s_axis_tready), DW'(1'b1));

    // Single-beat packet stamped at 0x1000.
    m_axis_tready = 1'b0;
    STAMP_COUNTER = 64'h1000;
    d0 = rnd_data();
    u0 = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_5555_AAAA};
    send_beat(d0, 32'hFFFF_FFFF, u0, 1'b1, wa, ts_a);
    chk("q33_valid", DW'(m_axis_tvalid), DW'(1'b1));
    chk("q33_last", DW'(m_axis_tlast), DW'(1'b1));
    chk("q33_stamp", DW'(m_axis_tuser[127:64]), DW'(64'h1000));
    chk("q33_user_low", DW'(m_axis_tuser[63:0]), DW'(64'h89AB_CDEF_5555_AAAA));
    chk("q33_data", m_axis_tdata, d0);
    chk("q33_pkt_count", DW'(PKT_COUNT), DW'(32'd1));
    drain();

    // Stall with both entries full; first beat waits from 0x20 and is taken at 0x24.
    base = obs_stamps.size();
    m_axis_tready = 1'b0;
    send_pkt(2, 1'b1, ts_a, u_a, wa);
    chk("q34_full_ready", DW'(s_axis_tready), DW'(1'b0));
    d0 = rnd_data();
    u0 = rnd_user();
    k0 = KW'($urandom());
    TIMESTAMP_EN  = 1'b1;
    STAMP_COUNTER = 64'h20;
    s_axis_tdata  = d0;
    s_axis_tkeep  = k0;
    s_axis_tuser  = u0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) m_axis_tready = 1'b1;
      chk("q34_hold_ready", DW'(s_axis_tready), DW'(i == 4));
      if (i < 4) step();
    end
    send_beat(d0, k0, u0, 1'b0, wa, ts_a);
    TIMESTAMP_EN = 1'b0;
    for (int i = 1; i < 4; i++) send_beat(rnd_data(), KW'($urandom()), rnd_user(), (i == 3), wa, ts_b);
    drain();
    chk("q34_stamp", DW'(obs_stamps[base + 1]), DW'(64'h24));

    // Back-to-back 3-beat packets at full rate.
    base = obs_stamps.size();
    send_pkt(3, 1'b1, ts_a, u_a, wa);
    send_pkt(3, 1'b1, ts_b, u_b, wb);
    chk("q35_no_bubbles", DW'(wa + wb), DW'(0));
    drain();
    chk("q35_stamp_delta", DW'(obs_stamps[base + 1] - obs_stamps[base]), DW'(64'd3));

    // Toggling sink, random source gaps, random packet sizes and enables.
    m_axis_tready = 1'b1;
    tog_mode = 1'b1;
    for (int p = 0; p < 100; p++) begin
      repeat ($urandom_range(0, 1)) step();
      send_pkt(int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)), ts_a, u_a, wa);
    end
    drain();

    // Packet count preset to all-ones: unstamped packet, then stamped one wraps it.
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    preset_val = 32'hFFFF_FFFF;
    preset_seq++;
    step();
    release dut.r_pkt_count;
    step();
    chk("q37_preset", DW'(PKT_COUNT), DW'(32'hFFFF_FFFF));
    base = obs_stamps.size();
    send_pkt(1, 1'b0, ts_a, u_a, wa);
    send_pkt(1, 1'b1, ts_b, u_b, wb);
    drain();
    chk("q37_unstamped", DW'(obs_stamps[base]), DW'(u_a[127:64]));
    chk("q37_stamped", DW'(obs_stamps[base + 1]), DW'(ts_b));
    chk("q37_wrap", DW'(PKT_COUNT), DW'(32'd0));

    // Reset pulse in the middle of a 4-beat packet.
    TIMESTAMP_EN = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(rnd_data(), KW'($urandom()), rnd_user(), 1'b0, wa, ts_a);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("q38_m_valid", DW'(m_axis_tvalid), DW'(1'b0));
    chk("q38_s_ready", DW'(s_axis_tready), DW'(1'b0));
    chk("q38_pkt_clear", DW'(PKT_COUNT), DW'(32'd0));
    step();
    chk("q38_ready_back", DW'(s_axis_tready), DW'(1'b1));
    base = obs_stamps.size();
    send_pkt(2, 1'b1, ts_a, u_a, wa);
    drain();
    chk("q38_stamp", DW'(obs_stamps[base]), DW'(ts_a));
    chk("q38_pkt_count", DW'(PKT_COUNT), DW'(32'd1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
